// File: rtl/fpu_sched_pkg.sv
// Shared definitions for the FPU op scheduler: op codes, FSM states and the
// per-op latency lookup.
package fpu_sched_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_FADD  = 4'd1,
    OP_FSUB  = 4'd2,
    OP_FMUL  = 4'd3,
    OP_FINV  = 4'd4,
    OP_FSQRT = 4'd5,
    OP_FNEG  = 4'd6,
    OP_FABS  = 4'd7,
    OP_FEQ   = 4'd8,
    OP_FLT   = 4'd9,
    OP_FLE   = 4'd10,
    OP_FMOV  = 4'd11,
    OP_ITOF  = 4'd12,
    OP_FTOI  = 4'd13,
    OP_FLI   = 4'd14,
    OP_HALT  = 4'd15
  } fpu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  function automatic int unsigned op_latency(input logic [3:0] ctrl,
                                             input int unsigned lat_add,
                                             input int unsigned lat_mul,
                                             input int unsigned lat_long);
    case (ctrl)
      OP_FADD, OP_FSUB:  return lat_add;
      OP_FMUL:           return lat_mul;
      OP_FINV, OP_FSQRT: return lat_long;
      default:           return 1;
    endcase
  endfunction

  function automatic int unsigned lat_max(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/fpu_rr_arb.sv
// Two-way round-robin arbiter; the pointer remembers the last granted
// requester and only moves when a grant is actually taken.
module fpu_rr_arb (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       update,
  output logic [1:0] grant
);

  logic last;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Reset value 1 makes requester 0 win the first contended grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last <= 1'b1;
    end else if (update) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/fpu_sched.sv
// Single-issue scheduler sharing one external combinational FPU datapath
// between two requesters, with a held write-back handshake.
module fpu_sched
  import fpu_sched_pkg::*;
#(
  parameter int unsigned LAT_ADD  = 2,
  parameter int unsigned LAT_MUL  = 2,
  parameter int unsigned LAT_LONG = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][3:0]  req_ctrl,
  input  logic [1:0][31:0] req_ds,
  input  logic [1:0][31:0] req_dt,
  input  logic [1:0][5:0]  req_dd,
  input  logic [1:0][15:0] req_imm,
  output logic [3:0]       fpu_ctrl,
  output logic [31:0]      fpu_ds_val,
  output logic [31:0]      fpu_dt_val,
  output logic [5:0]       fpu_dd,
  output logic [15:0]      fpu_imm,
  input  logic [5:0]       fpu_reg_addr,
  input  logic [31:0]      fpu_dd_val,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [5:0]       wb_addr,
  output logic [31:0]      wb_val,
  output logic             wb_src,
  input  logic             flush,
  output logic             busy
);

  localparam int unsigned LAT_MAX = lat_max(LAT_ADD, LAT_MUL, LAT_LONG);
  localparam int unsigned CW      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [1:0]    grant;
  logic          arb_enable;
  logic          accept;
  logic          sel;
  logic          src_q;

  // Gating with rstn keeps req_ready low while reset is held.
  assign arb_enable = rstn && !flush && (state == ST_IDLE);

  fpu_rr_arb u_arb (
    .clk    (clk),
    .rstn   (rstn),
    .req    (req_valid),
    .enable (arb_enable),
    .update (accept),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);
  assign sel       = grant[1];
  assign busy      = (state != ST_IDLE);
  assign wb_valid  = (state == ST_WB);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (accept) state_next = ST_EXEC;
      ST_EXEC: begin
        if (cnt == '0) begin
          state_next = (fpu_reg_addr == 6'd0) ? ST_IDLE : ST_WB;
        end
      end
      ST_WB:   if (wb_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt        <= '0;
      src_q      <= 1'b0;
      fpu_ctrl   <= '0;
      fpu_ds_val <= '0;
      fpu_dt_val <= '0;
      fpu_dd     <= '0;
      fpu_imm    <= '0;
      wb_addr    <= '0;
      wb_val     <= '0;
      wb_src     <= 1'b0;
    end else if (accept) begin
      fpu_ctrl   <= req_ctrl[sel];
      fpu_ds_val <= req_ds[sel];
      fpu_dt_val <= req_dt[sel];
      fpu_dd     <= req_dd[sel];
      fpu_imm    <= req_imm[sel];
      src_q      <= sel;
      cnt        <= CW'(op_latency(req_ctrl[sel], LAT_ADD, LAT_MUL, LAT_LONG) - 32'd1);
    end else if (state == ST_EXEC && !flush) begin
      if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end else if (fpu_reg_addr != 6'd0) begin
        wb_addr <= fpu_reg_addr;
        wb_val  <= fpu_dd_val;
        wb_src  <= src_q;
      end
    end
  end

endmodule

// File: tb/tb_fpu_sched.sv
// Scoreboard bench for fpu_sched with a behavioural stand-in for the FPU
// datapath.
module tb_fpu_sched;

  localparam int unsigned LAT_ADD  = 2;
  localparam int unsigned LAT_MUL  = 2;
  localparam int unsigned LAT_LONG = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][3:0]  req_ctrl;
  logic [1:0][31:0] req_ds;
  logic [1:0][31:0] req_dt;
  logic [1:0][5:0]  req_dd;
  logic [1:0][15:0] req_imm;
  logic [3:0]       fpu_ctrl;
  logic [31:0]      fpu_ds_val;
  logic [31:0]      fpu_dt_val;
  logic [5:0]       fpu_dd;
  logic [15:0]      fpu_imm;
  logic [5:0]       fpu_reg_addr;
  logic [31:0]      fpu_dd_val;
  logic             wb_valid;
  logic             wb_ready;
  logic [5:0]       wb_addr;
  logic [31:0]      wb_val;
  logic             wb_src;
  logic             flush;
  logic             busy;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] val;
    logic        src;
  } wb_exp_t;

  wb_exp_t sb[$];
  int tests_run = 0;
  int tests_failed = 0;

  fpu_sched #(
    .LAT_ADD  (LAT_ADD),
    .LAT_MUL  (LAT_MUL),
    .LAT_LONG (LAT_LONG)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_ctrl     (req_ctrl),
    .req_ds       (req_ds),
    .req_dt       (req_dt),
    .req_dd       (req_dd),
    .req_imm      (req_imm),
    .fpu_ctrl     (fpu_ctrl),
    .fpu_ds_val   (fpu_ds_val),
    .fpu_dt_val   (fpu_dt_val),
    .fpu_dd       (fpu_dd),
    .fpu_imm      (fpu_imm),
    .fpu_reg_addr (fpu_reg_addr),
    .fpu_dd_val   (fpu_dd_val),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_addr      (wb_addr),
    .wb_val       (wb_val),
    .wb_src       (wb_src),
    .flush        (flush),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Stand-in datapath: fadd handles positive normal operands, ctrl 14 turns
  // imm/2 into a float, anything else produces a recognisable bit mix.
  function automatic logic [31:0] fpu_model(input logic [3:0] ctrl, input logic [31:0] a,
                                            input logic [31:0] b, input logic [15:0] imm);
    logic [7:0]  ea, eb, er;
    logic [24:0] ma, mb, ms;
    logic [15:0] v;
    logic [38:0] t;
    int          p;
    logic [31:0] r;
    r = a ^ b ^ {16'h0, imm};
    if (ctrl == 4'd1) begin
      ma = {2'b01, a[22:0]};
      mb = {2'b01, b[22:0]};
      ea = a[30:23];
      eb = b[30:23];
      if (ea < eb) begin
        ms = ma; ma = mb; mb = ms;
        er = ea; ea = eb; eb = er;
      end
      mb = mb >> (ea - eb);
      ms = ma + mb;
      er = ea;
      if (ms[24]) begin
        ms = ms >> 1;
        er = er + 8'd1;
      end
      r = {1'b0, er, ms[22:0]};
    end else if (ctrl == 4'd14) begin
      v = imm >> 1;
      p = 0;
      for (int i = 0; i < 16; i++) if (v[i]) p = i;
      t = {23'b0, v} << (23 - p);
      r = (v == 16'h0) ? 32'h0 : {1'b0, 8'(127 + p), t[22:0]};
    end
    return r;
  endfunction

  always_comb begin
    fpu_reg_addr = (fpu_ctrl == 4'd0 || fpu_ctrl == 4'd15) ? 6'd0 : fpu_dd;
    fpu_dd_val   = fpu_model(fpu_ctrl, fpu_ds_val, fpu_dt_val, fpu_imm);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    step();
  endtask

  task automatic drive_req(input int r, input logic [3:0] ctrl, input logic [31:0] ds,
                           input logic [31:0] dt, input logic [5:0] dd, input logic [15:0] imm);
    req_ctrl[r] = ctrl;
    req_ds[r]   = ds;
    req_dt[r]   = dt;
    req_dd[r]   = dd;
    req_imm[r]  = imm;
  endtask

  task automatic wait_wb(output int cycles);
    cycles = -1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (wb_valid === 1'b1) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req_valid = 2'b11;
    drive_req(0, 4'd1, 32'h1, 32'h2, 6'd3, 16'h4);
    drive_req(1, 4'd3, 32'h5, 32'h6, 6'd7, 16'h8);
    #12;
    tests_run++;
    if (req_ready !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready: got %b expected 00", req_ready);
    end
    tests_run++;
    if ({busy, wb_valid} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_busy_wb: got %b expected 00", {busy, wb_valid});
    end
    tests_run++;
    if ({fpu_ctrl, fpu_ds_val, fpu_dt_val, fpu_dd, fpu_imm, wb_addr, wb_val, wb_src} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got ctrl=%h ds=%h dd=%h wb_addr=%h wb_val=%h expected all 0",
               fpu_ctrl, fpu_ds_val, fpu_dd, wb_addr, wb_val);
    end
    req_valid = 2'b00;
    @(negedge clk);
    rstn = 1'b1;
    step();
  endtask

  task automatic test_fadd();
    int cyc;
    wb_exp_t e;
    drive_req(0, 4'd1, 32'h3F800000, 32'h40000000, 6'd5, 16'h0);
    req_valid = 2'b01;
    sb.push_back('{addr: 6'd5, val: 32'h40400000, src: 1'b0});
    #1;
    tests_run++;
    if (req_ready !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL fadd_ready: got %b expected 01", req_ready);
    end
    step();
    req_valid = 2'b00;
    #1;
    tests_run++;
    if ({busy, fpu_ctrl, fpu_ds_val, fpu_dt_val, fpu_dd} !== {1'b1, 4'd1, 32'h3F800000, 32'h40000000, 6'd5}) begin
      tests_failed++;
      $display("[TB] FAIL fadd_issue: got busy=%b ctrl=%h ds=%h dt=%h dd=%h expected 1/1/3f800000/40000000/05",
               busy, fpu_ctrl, fpu_ds_val, fpu_dt_val, fpu_dd);
    end
    wait_wb(cyc);
    tests_run++;
    if (cyc !== int'(LAT_ADD)) begin
      tests_failed++;
      $display("[TB] FAIL fadd_latency: got %0d expected %0d", cyc, LAT_ADD);
    end
    e = sb.pop_front();
    tests_run++;
    if ({wb_addr, wb_val, wb_src} !== {e.addr, e.val, e.src}) begin
      tests_failed++;
      $display("[TB] FAIL fadd_wb: got addr=%h val=%h src=%b expected addr=%h val=%h src=%b",
               wb_addr, wb_val, wb_src, e.addr, e.val, e.src);
    end
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    #1;
    tests_run++;
    if ({busy, wb_valid} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL fadd_done: got busy/wb_valid=%b expected 00", {busy, wb_valid});
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    wb_exp_t e;
    logic [1:0] exp_grant;
    apply_reset();
    drive_req(0, 4'd14, 32'h11111111, 32'h22222222, 6'd10, 16'd2);
    drive_req(1, 4'd14, 32'h33333333, 32'h44444444, 6'd11, 16'd2);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_grant = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      tests_run++;
      if (req_ready !== exp_grant) begin
        tests_failed++;
        $display("[TB] FAIL rr_grant%0d: got %b expected %b", i, req_ready, exp_grant);
      end
      sb.push_back('{addr: (i % 2 == 0) ? 6'd10 : 6'd11, val: 32'h3F800000, src: (i % 2 == 1)});
      step();
      wait_wb(cyc);
      tests_run++;
      if (cyc !== 1) begin
        tests_failed++;
        $display("[TB] FAIL rr_latency%0d: got %0d expected 1", i, cyc);
      end
      e = sb.pop_front();
      tests_run++;
      if ({wb_addr, wb_val, wb_src} !== {e.addr, e.val, e.src}) begin
        tests_failed++;
        $display("[TB] FAIL rr_wb%0d: got addr=%h val=%h src=%b expected addr=%h val=%h src=%b",
                 i, wb_addr, wb_val, wb_src, e.addr, e.val, e.src);
      end
      wb_ready = 1'b1;
      #1;
      tests_run++;
      if (req_ready !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL rr_wb_cycle_ready%0d: got %b expected 00", i, req_ready);
      end
      step();
      wb_ready = 1'b0;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_wb_stall();
    int cyc;
    wb_exp_t e;
    drive_req(1, 4'd4, 32'h40800000, 32'h12345678, 6'd20, 16'h00AA);
    req_valid = 2'b10;
    sb.push_back('{addr: 6'd20, val: fpu_model(4'd4, 32'h40800000, 32'h12345678, 16'h00AA), src: 1'b1});
    #1;
    tests_run++;
    if (req_ready !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL stall_ready: got %b expected 10", req_ready);
    end
    step();
    wait_wb(cyc);
    tests_run++;
    if (cyc !== int'(LAT_LONG)) begin
      tests_failed++;
      $display("[TB] FAIL stall_latency: got %0d expected %0d", cyc, LAT_LONG);
    end
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({wb_valid, wb_addr, wb_val, wb_src, req_ready} !== {1'b1, e.addr, e.val, e.src, 2'b00}) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold%0d: got v=%b addr=%h val=%h src=%b ready=%b expected v=1 addr=%h val=%h src=%b ready=00",
                 i, wb_valid, wb_addr, wb_val, wb_src, req_ready, e.addr, e.val, e.src);
      end
      step();
    end
    wb_ready = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL stall_release_ready: got %b expected 00", req_ready);
    end
    step();
    wb_ready = 1'b0;
    #1;
    tests_run++;
    if ({wb_valid, req_ready} !== 3'b010) begin
      tests_failed++;
      $display("[TB] FAIL stall_after: got wb_valid/ready=%b expected 010", {wb_valid, req_ready});
    end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_nop_skip();
    int cyc;
    wb_exp_t e;
    drive_req(0, 4'd0, 32'h0, 32'h0, 6'd7, 16'h0);
    req_valid = 2'b01;
    #1;
    tests_run++;
    if (req_ready !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL nop_ready: got %b expected 01", req_ready);
    end
    step();
    drive_req(0, 4'd6, 32'hA5A5A5A5, 32'h0F0F0F0F, 6'd8, 16'h1234);
    #1;
    tests_run++;
    if ({busy, wb_valid, req_ready} !== 4'b1000) begin
      tests_failed++;
      $display("[TB] FAIL nop_exec: got busy/wb_valid/ready=%b expected 1000", {busy, wb_valid, req_ready});
    end
    step();
    tests_run++;
    if ({busy, wb_valid} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL nop_skip: got busy/wb_valid=%b expected 00", {busy, wb_valid});
    end
    #1;
    tests_run++;
    if (req_ready !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL nop_next_ready: got %b expected 01", req_ready);
    end
    sb.push_back('{addr: 6'd8, val: fpu_model(4'd6, 32'hA5A5A5A5, 32'h0F0F0F0F, 16'h1234), src: 1'b0});
    step();
    req_valid = 2'b00;
    wait_wb(cyc);
    e = sb.pop_front();
    tests_run++;
    if ({cyc == 1, wb_addr, wb_val, wb_src} !== {1'b1, e.addr, e.val, e.src}) begin
      tests_failed++;
      $display("[TB] FAIL nop_next_wb: got cyc=%0d addr=%h val=%h src=%b expected cyc=1 addr=%h val=%h src=%b",
               cyc, wb_addr, wb_val, wb_src, e.addr, e.val, e.src);
    end
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic seen_wb;
    drive_req(0, 4'd5, 32'h40800000, 32'h0, 6'd9, 16'h0);
    req_valid = 2'b01;
    #1;
    tests_run++;
    if (req_ready !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL flush_ready: got %b expected 01", req_ready);
    end
    step();
    req_valid = 2'b00;
    step();
    flush = 1'b1;
    req_valid = 2'b11;
    #1;
    tests_run++;
    if ({req_ready, busy} !== 3'b001) begin
      tests_failed++;
      $display("[TB] FAIL flush_cycle: got ready/busy=%b expected 001", {req_ready, busy});
    end
    step();
    flush = 1'b0;
    req_valid = 2'b00;
    #1;
    tests_run++;
    if ({busy, wb_valid} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL flush_idle: got busy/wb_valid=%b expected 00", {busy, wb_valid});
    end
    seen_wb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen_wb = seen_wb | wb_valid;
    end
    tests_run++;
    if (seen_wb !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL flush_no_wb: got wb_valid seen=%b expected 0", seen_wb);
    end
    req_valid = 2'b11;
    #1;
    tests_run++;
    if (req_ready !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL flush_rr_ptr: got %b expected 10", req_ready);
    end
    req_valid = 2'b00;
    step();
  endtask

  task automatic test_reset_mid_exec();
    logic seen_wb;
    drive_req(1, 4'd3, 32'h40400000, 32'h40000000, 6'd12, 16'h0);
    req_valid = 2'b10;
    #1;
    step();
    req_valid = 2'b00;
    #1;
    tests_run++;
    if ({busy, fpu_ctrl} !== {1'b1, 4'd3}) begin
      tests_failed++;
      $display("[TB] FAIL rst_exec_issue: got busy=%b ctrl=%h expected 1/3", busy, fpu_ctrl);
    end
    req_valid = 2'b11;
    rstn = 1'b0;
    #1;
    tests_run++;
    if ({busy, wb_valid, req_ready, fpu_ctrl, fpu_ds_val, fpu_dd, wb_addr, wb_val, wb_src} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rst_exec_outputs: got busy=%b wb_valid=%b ready=%b ctrl=%h ds=%h wb_addr=%h wb_val=%h expected all 0",
               busy, wb_valid, req_ready, fpu_ctrl, fpu_ds_val, wb_addr, wb_val);
    end
    req_valid = 2'b00;
    @(negedge clk);
    rstn = 1'b1;
    seen_wb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen_wb = seen_wb | wb_valid | busy;
    end
    tests_run++;
    if (seen_wb !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_exec_no_wb: got activity=%b expected 0", seen_wb);
    end
    req_valid = 2'b11;
    #1;
    tests_run++;
    if (req_ready !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL rst_rr_ptr: got %b expected 01", req_ready);
    end
    req_valid = 2'b00;
  endtask

  initial begin
    req_valid = 2'b00;
    wb_ready  = 1'b0;
    flush     = 1'b0;
    test_reset();
    test_fadd();
    test_back_to_back();
    test_wb_stall();
    test_nop_skip();
    test_flush();
    test_reset_mid_exec();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
